// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder among NREQ requesters.
// Optional saturating add is enabled by defining ADDER_ARB_SAT_EN.
module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_carry,
    output logic [IDW-1:0]        res_id
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDW-1:0]   r_id;

    logic             w_slot_free;
    logic             w_grant;
    logic             w_found;
    logic [IDW-1:0]   w_gnt_idx;
    logic [IDW-1:0]   w_cand;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;

    // A full slot counts as free when the consumer drains it this same cycle.
    assign w_slot_free = (r_state == ST_EMPTY) || res_ready;

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_grant   = rst_n && w_slot_free && ena && w_found;
    assign req_ready = w_grant ? (NREQ'(1) << w_gnt_idx) : '0;

    assign w_a   = req_a[w_gnt_idx*WIDTH +: WIDTH];
    assign w_b   = req_b[w_gnt_idx*WIDTH +: WIDTH];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= IDW'(NREQ - 1);
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
        end else if (w_grant) begin
            r_state <= ST_FULL;
            r_ptr   <= w_gnt_idx;
            r_id    <= w_gnt_idx;
            r_carry <= w_sum[WIDTH];
`ifdef ADDER_ARB_SAT_EN
            r_sum   <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
            r_sum   <= w_sum[WIDTH-1:0];
`endif
        end else if (w_slot_free) begin
            r_state <= ST_EMPTY;
        end
    end

    assign res_valid = (r_state == ST_FULL);
    assign res_sum   = r_sum;
    assign res_carry = r_carry;
    assign res_id    = r_id;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed self-checking bench for adder_share_arb (NREQ=4, WIDTH=8).
module tb_adder_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  ena;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_carry;
    logic [IDW-1:0]        res_id;

    int checkCount;
    int errorCount;

    adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_valid[idx]           = 1'b1;
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] expGrant;
    logic [7:0] overflowSum;

    initial begin
        checkCount = 0;
        errorCount = 0;
`ifdef ADDER_ARB_SAT_EN
        overflowSum = 8'hFF;
`else
        overflowSum = 8'h10;
`endif
        rst_n     = 1'b0;
        ena       = 1'b1;
        res_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'(i + 1), 8'h10);

        #3;
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
        checkOutput("rst_res_sum", 32'(res_sum), 32'h0);
        checkOutput("rst_res_carry", 32'(res_carry), 32'h0);
        checkOutput("rst_res_id", 32'(res_id), 32'h0);

        #4 rst_n = 1'b1;
        #1;
        // Fairness: all valid, grants rotate 0,1,2,3,0,1.
        for (int k = 0; k < 6; k++) begin
            expGrant = 4'b0001 << (k % 4);
            checkOutput("rr_grant", 32'(req_ready), 32'(expGrant));
            tick();
            checkOutput("rr_res_valid", 32'(res_valid), 32'h1);
            checkOutput("rr_res_id", 32'(res_id), 32'(k % 4));
            checkOutput("rr_res_sum", 32'(res_sum), 32'(8'h11 + 8'(k % 4)));
        end

        req_valid = '0;
        tick();
        checkOutput("drain_empty", 32'(res_valid), 32'h0);

        // Single request from requester 2.
        applyStimulus(2, 8'h12, 8'h34);
        #1;
        checkOutput("single_grant", 32'(req_ready), 32'h4);
        tick();
        checkOutput("single_valid", 32'(res_valid), 32'h1);
        checkOutput("single_sum", 32'(res_sum), 32'h46);
        checkOutput("single_carry", 32'(res_carry), 32'h0);
        checkOutput("single_id", 32'(res_id), 32'h2);

        // Backpressure: hold result, requester 1 waits.
        req_valid = '0;
        res_ready = 1'b0;
        applyStimulus(1, 8'h01, 8'h02);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("bp_no_grant", 32'(req_ready), 32'h0);
            tick();
            checkOutput("bp_valid", 32'(res_valid), 32'h1);
            checkOutput("bp_sum", 32'(res_sum), 32'h46);
            checkOutput("bp_id", 32'(res_id), 32'h2);
        end
        res_ready = 1'b1;
        #1;
        checkOutput("bp_release_grant", 32'(req_ready), 32'h2);
        tick();
        checkOutput("bp_new_valid", 32'(res_valid), 32'h1);
        checkOutput("bp_new_id", 32'(res_id), 32'h1);
        checkOutput("bp_new_sum", 32'(res_sum), 32'h03);

        // Overflow from requester 3.
        req_valid = '0;
        applyStimulus(3, 8'hF0, 8'h20);
        #1;
        checkOutput("ovf_grant", 32'(req_ready), 32'h8);
        tick();
        checkOutput("ovf_sum", 32'(res_sum), 32'(overflowSum));
        checkOutput("ovf_carry", 32'(res_carry), 32'h1);
        checkOutput("ovf_id", 32'(res_id), 32'h3);

        // ena=0 blocks grants but the held result still drains.
        req_valid = '0;
        ena       = 1'b0;
        res_ready = 1'b0;
        applyStimulus(0, 8'h05, 8'h06);
        applyStimulus(2, 8'h07, 8'h08);
        #1;
        checkOutput("ena_hold_grant", 32'(req_ready), 32'h0);
        tick();
        checkOutput("ena_hold_valid", 32'(res_valid), 32'h1);
        res_ready = 1'b1;
        #1;
        checkOutput("ena_drain_grant", 32'(req_ready), 32'h0);
        tick();
        checkOutput("ena_drained", 32'(res_valid), 32'h0);
        checkOutput("ena_sum_kept", 32'(res_sum), 32'(overflowSum));
        tick();
        checkOutput("ena_still_empty", 32'(res_valid), 32'h0);
        ena = 1'b1;
        #1;
        checkOutput("ena_resume_grant", 32'(req_ready), 32'h1);
        tick();
        checkOutput("ena_resume_id", 32'(res_id), 32'h0);
        checkOutput("ena_resume_sum", 32'(res_sum), 32'h0B);
        checkOutput("ena_resume_valid", 32'(res_valid), 32'h1);

        // Mid-operation reset without a clock edge.
        req_valid = '0;
        applyStimulus(2, 8'h07, 8'h08);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(res_valid), 32'h0);
        checkOutput("mid_rst_sum", 32'(res_sum), 32'h0);
        checkOutput("mid_rst_id", 32'(res_id), 32'h0);
        checkOutput("mid_rst_grant", 32'(req_ready), 32'h0);
        req_valid = 4'b1111;
        #1 rst_n = 1'b1;
        #1;
        checkOutput("post_rst_grant", 32'(req_ready), 32'h1);
        tick();
        checkOutput("post_rst_id", 32'(res_id), 32'h0);
        checkOutput("post_rst_valid", 32'(res_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares one registered WIDTH-bit adder between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block picks one winner per cycle, registers sum, carry-out and winner ID into a single output slot, and holds that slot until the consumer accepts it. It sits between the pin-level operand sources and the output mux in the top-level Tiny Tapeout wrapper.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand and sum width
- IDW, $clog2(NREQ), width of res_id

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  global enable; when 0, no new grants (held result still drains)
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  one-hot grant; handshake completes in the cycle valid&ready
- req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- res_valid  output  1  result slot full
- res_ready  input  1  consumer accepts result
- res_sum  output  WIDTH  registered sum
- res_carry  output  1  registered carry-out (overflow flag)
- res_id  output  IDW  index of the requester that produced res_sum

## Operation
- States: EMPTY (res_valid=0) and FULL (res_valid=1).
- Slot is free when state==EMPTY, or when state==FULL and res_ready=1.
- Grant:
  - If the slot is free, ena=1 and any req_valid is set, exactly one req_ready bit goes high combinationally.
  - The winner is the first set req_valid searching from ptr+1 upward, modulo NREQ.
  - Otherwise req_ready = 0.
- On grant to requester g:
  - {res_carry, res_sum} <= req_a[g] + req_b[g], computed at WIDTH+1 bits.
  - res_id <= g; ptr <= g; state <= FULL.
- Slot free with no grant: state <= EMPTY. res_sum, res_carry and res_id keep their last values.
- FULL with res_ready=0: all outputs stable and req_ready=0.
- Requesters hold req_valid, req_a and req_b stable until their ready. A requester that drops valid before grant simply loses its turn; nothing is corrupted.
- Round-robin pointer ptr resets to NREQ-1, so requester 0 wins first after reset. No requester waits more than NREQ-1 grants while continuously valid.
- ena=0 blocks new grants only; a held result still drains on res_ready.

## Timing
- Latency: operands accepted in cycle N give res_valid=1 in cycle N+1.
- Throughput: one result per cycle when res_ready is held at 1, because drain and accept happen in the same cycle.
- req_ready depends combinationally on req_valid, res_ready, ena and state. There is no combinational path from req_a or req_b to any output.
- Reset values (asserted asynchronously while rst_n=0):
  - res_valid=0, res_sum=0, res_carry=0, res_id=0
  - ptr=NREQ-1, state=EMPTY
  - req_ready forced 0
- Reset mid-operation: a held result is discarded immediately, and any in-flight handshake is cancelled. After release, arbitration restarts from requester 0.
- Simultaneous drain and accept: the new result overwrites the slot in the same edge; res_valid stays 1.

## Configuration
- ADDER_ARB_SAT_EN defined:
  - On carry-out, res_sum <= all ones (saturating add).
  - res_carry still reports the overflow.
- ADDER_ARB_SAT_EN undefined: res_sum is the modulo-2^WIDTH sum (wrap-around).

## Test plan
- Reset: rst_n=0 with req_valid=4'b1111 -> req_ready=0, res_valid=0, res_sum=0x00, res_id=0. After release, the first grant goes to requester 0.
- Single request: req 2 with a=0x12, b=0x34, res_ready=1 -> req_ready=4'b0100 in cycle N; in cycle N+1 res_valid=1, res_sum=0x46, res_carry=0, res_id=2.
- Fairness: all four requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, and res_id follows one cycle later.
- Backpressure: result held with res_ready=0 for 5 cycles -> req_ready=0 and res_* unchanged. Raising res_ready with req 1 valid -> drain and new accept in the same cycle, res_id=1 next cycle.
- Overflow: a=0xF0, b=0x20 -> res_sum=0x10, res_carry=1. With ADDER_ARB_SAT_EN -> res_sum=0xFF, res_carry=1.
- Mid-operation reset and ena: rst_n pulsed low while res_valid=1 -> res_valid drops without waiting for a clock edge. With ena=0 and requests pending -> no grants, but a held result still drains on res_ready.
